ins_l1_fill_controller: RTL and testbench

- Initiator side of the instruction-cache L1-to-L2 refill interface: on an L1 instruction-cache miss it fetches the whole line from L2, one word at a time.
- Each word uses one address beat on the ADDRESS_TO_L2 channel and one data beat on the DATA_FROM_L2 channel (valid/ready on both).
- Fetch order is critical-word-first with wrap-around; each returned word is written into the L1 line array through a registered fill port.
- Sits between the L1 instruction cache miss logic and the L2 port of RISCV_PROCESSOR.

---
 rtl/ins_l1_fill_controller_if.sv | 43 ++++
 rtl/ins_l1_fill_controller.sv | 129 ++++++++++++
 tb/tb_ins_l1_fill_controller.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ins_l1_fill_controller_if.sv
// L1 instruction-cache refill bundle: miss request from L1, address/data channels
// to L2, and the registered fill-write port into the L1 line array.
interface ins_l1_fill_controller_if #(
    parameter int ADDRESS_WIDTH      = 32,
    parameter int L2_BUS_WIDTH       = 32,
    parameter int BLOCK_OFFSET_WIDTH = 2
);
    logic                          miss_valid;
    logic [ADDRESS_WIDTH-1:0]      miss_address;
    logic                          miss_ready;
    logic                          flush;

    logic                          address_to_l2_ready_ins;
    logic                          address_to_l2_valid_ins;
    logic [ADDRESS_WIDTH-3:0]      address_to_l2_ins;

    logic                          data_from_l2_valid_ins;
    logic                          data_from_l2_ready_ins;
    logic [L2_BUS_WIDTH-1:0]       data_from_l2_ins;

    logic                          fill_write_enable;
    logic [BLOCK_OFFSET_WIDTH-1:0] fill_word_offset;
    logic [L2_BUS_WIDTH-1:0]       fill_data;
    logic                          fill_done;

    // Controller side
    modport master (
        input  miss_valid, miss_address, flush,
        input  address_to_l2_ready_ins, data_from_l2_valid_ins, data_from_l2_ins,
        output miss_ready,
        output address_to_l2_valid_ins, address_to_l2_ins, data_from_l2_ready_ins,
        output fill_write_enable, fill_word_offset, fill_data, fill_done
    );

    // Environment side (L1 miss logic, L2 port, line array)
    modport slave (
        output miss_valid, miss_address, flush,
        output address_to_l2_ready_ins, data_from_l2_valid_ins, data_from_l2_ins,
        input  miss_ready,
        input  address_to_l2_valid_ins, address_to_l2_ins, data_from_l2_ready_ins,
        input  fill_write_enable, fill_word_offset, fill_data, fill_done
    );
endinterface

// File: rtl/ins_l1_fill_controller.sv
// Critical-word-first L1 instruction line refill: one L2 address beat and one data
// beat per word, wrapping within the line; FLUSH drains the bus but drops the writes.
module ins_l1_fill_controller #(
    parameter int ADDRESS_WIDTH      = 32,
    parameter int L2_BUS_WIDTH       = 32,
    parameter int BLOCK_OFFSET_WIDTH = 2
) (
    input  logic clk,
    input  logic rst,
    ins_l1_fill_controller_if.master bus
);
    localparam int LINE_WIDTH = ADDRESS_WIDTH - 2 - BLOCK_OFFSET_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                        state_reg;
    logic [LINE_WIDTH-1:0]         line_reg;
    logic [BLOCK_OFFSET_WIDTH-1:0] offset_reg;
    logic [BLOCK_OFFSET_WIDTH-1:0] count_reg;
    logic                          abort_reg;

    logic                          miss_ready_reg;
    logic                          addr_valid_reg;
    logic [ADDRESS_WIDTH-3:0]      addr_reg;
    logic                          data_ready_reg;
    logic                          fill_we_reg;
    logic [BLOCK_OFFSET_WIDTH-1:0] fill_offset_reg;
    logic [L2_BUS_WIDTH-1:0]       fill_data_reg;
    logic                          fill_done_reg;

    logic                          abort_next;
    logic [BLOCK_OFFSET_WIDTH-1:0] offset_inc;
    logic                          last_beat;
    logic                          unused_addr_bits;

    // A flush arriving on the same edge as a data beat already suppresses that write.
    assign abort_next       = abort_reg | bus.flush;
    assign offset_inc       = offset_reg + 1'b1;
    assign last_beat        = &count_reg;
    assign unused_addr_bits = ^bus.miss_address[1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= IDLE;
            line_reg        <= '0;
            offset_reg      <= '0;
            count_reg       <= '0;
            abort_reg       <= 1'b0;
            miss_ready_reg  <= 1'b1;
            addr_valid_reg  <= 1'b0;
            addr_reg        <= '0;
            data_ready_reg  <= 1'b0;
            fill_we_reg     <= 1'b0;
            fill_offset_reg <= '0;
            fill_data_reg   <= '0;
            fill_done_reg   <= 1'b0;
        end else begin
            fill_we_reg   <= 1'b0;
            fill_done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.miss_valid) begin
                        line_reg       <= bus.miss_address[ADDRESS_WIDTH-1:2+BLOCK_OFFSET_WIDTH];
                        offset_reg     <= bus.miss_address[BLOCK_OFFSET_WIDTH+1:2];
                        count_reg      <= '0;
                        abort_reg      <= 1'b0;
                        addr_reg       <= bus.miss_address[ADDRESS_WIDTH-1:2];
                        addr_valid_reg <= 1'b1;
                        miss_ready_reg <= 1'b0;
                        state_reg      <= REQ;
                    end
                end
                REQ: begin
                    abort_reg <= abort_next;
                    if (bus.address_to_l2_ready_ins) begin
                        addr_valid_reg <= 1'b0;
                        data_ready_reg <= 1'b1;
                        state_reg      <= RESP;
                    end
                end
                RESP: begin
                    abort_reg <= abort_next;
                    if (bus.data_from_l2_valid_ins) begin
                        fill_data_reg   <= bus.data_from_l2_ins;
                        fill_offset_reg <= offset_reg;
                        fill_we_reg     <= ~abort_next;
                        offset_reg      <= offset_inc;
                        count_reg       <= count_reg + 1'b1;
                        data_ready_reg  <= 1'b0;
                        if (last_beat) begin
                            fill_done_reg <= ~abort_next;
                            state_reg     <= DONE;
                        end else begin
                            // Offset wraps inside the line; the line bits never change.
                            addr_reg       <= {line_reg, offset_inc};
                            addr_valid_reg <= 1'b1;
                            state_reg      <= REQ;
                        end
                    end
                end
                DONE: begin
                    abort_reg      <= abort_next;
                    miss_ready_reg <= 1'b1;
                    state_reg      <= IDLE;
                end
                default: begin
                    state_reg      <= IDLE;
                    miss_ready_reg <= 1'b1;
                    addr_valid_reg <= 1'b0;
                    data_ready_reg <= 1'b0;
                end
            endcase
        end
    end

    assign bus.miss_ready              = miss_ready_reg;
    assign bus.address_to_l2_valid_ins = addr_valid_reg;
    assign bus.address_to_l2_ins       = addr_reg;
    assign bus.data_from_l2_ready_ins  = data_ready_reg;
    assign bus.fill_write_enable       = fill_we_reg;
    assign bus.fill_word_offset        = fill_offset_reg;
    assign bus.fill_data               = fill_data_reg;
    assign bus.fill_done               = fill_done_reg;
endmodule

// File: tb/tb_ins_l1_fill_controller.sv
// Scoreboard bench for the L1 instruction refill controller with a small L2 model
// returning mem[a] = a*3, configurable address stall and data delay.
module tb_ins_l1_fill_controller;
    localparam int AW  = 32;
    localparam int BW  = 32;
    localparam int BOW = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ins_l1_fill_controller_if #(.ADDRESS_WIDTH(AW), .L2_BUS_WIDTH(BW), .BLOCK_OFFSET_WIDTH(BOW)) bus ();

    ins_l1_fill_controller #(.ADDRESS_WIDTH(AW), .L2_BUS_WIDTH(BW), .BLOCK_OFFSET_WIDTH(BOW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [1:0]  off;
        logic [31:0] data;
    } fill_t;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [29:0] exp_addr_q[$];
    fill_t       exp_fill_q[$];
    logic [29:0] resp_q[$];
    int          fill_cyc_q[$];

    int addr_stall_cfg = 0;
    int data_delay_cfg = 0;
    bit stray          = 1'b0;

    int n_addr, n_data, n_write, n_done;
    int accept_cyc, done_cyc, ready_cyc;
    int cyc = 0;

    int          addr_wait = 0;
    int          data_wait = 0;
    logic        held_valid = 1'b0;
    logic [29:0] held_addr;
    logic        prev_miss_ready = 1'b1;
    fill_t       mon_fill;
    logic [29:0] mon_addr;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] l2_word(input logic [29:0] a);
        return {2'b00, a} * 32'd3;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // L2 model + output monitor: decisions made at negedge take effect on the next posedge.
    always @(negedge clk) begin
        if (rst) begin
            resp_q.delete();
            addr_wait = 0;
            data_wait = 0;
            held_valid = 1'b0;
            prev_miss_ready = 1'b1;
            bus.address_to_l2_ready_ins = 1'b0;
            bus.data_from_l2_valid_ins  = 1'b0;
            bus.data_from_l2_ins        = '0;
        end else begin
            if (bus.miss_valid && bus.miss_ready) accept_cyc = cyc + 1;
            if (bus.miss_ready && !prev_miss_ready) ready_cyc = cyc;
            prev_miss_ready = bus.miss_ready;

            if (bus.fill_write_enable) begin
                n_write++;
                fill_cyc_q.push_back(cyc);
                $display("[TB] fill cyc=%0d off=%0d data=0x%0h", cyc, bus.fill_word_offset, bus.fill_data);
                if (exp_fill_q.size() == 0) begin
                    check_val("unexpected_fill", 1, 0);
                end else begin
                    mon_fill = exp_fill_q.pop_front();
                    check_val("fill_offset", bus.fill_word_offset, mon_fill.off);
                    check_val("fill_data", bus.fill_data, mon_fill.data);
                end
            end
            if (bus.fill_done) begin
                n_done++;
                done_cyc = cyc;
            end

            // Data channel first so a word address accepted this cycle is not answered early.
            if (stray) begin
                check_val("stray_ready", bus.data_from_l2_ready_ins, 0);
                bus.data_from_l2_valid_ins = 1'b1;
                bus.data_from_l2_ins       = 32'hDEAD_BEEF;
            end else if (resp_q.size() > 0) begin
                if (data_wait < data_delay_cfg) begin
                    data_wait++;
                    bus.data_from_l2_valid_ins = 1'b0;
                end else begin
                    bus.data_from_l2_valid_ins = 1'b1;
                    bus.data_from_l2_ins       = l2_word(resp_q[0]);
                    if (bus.data_from_l2_ready_ins) begin
                        void'(resp_q.pop_front());
                        n_data++;
                        data_wait = 0;
                    end
                end
            end else begin
                bus.data_from_l2_valid_ins = 1'b0;
            end

            if (bus.address_to_l2_valid_ins) begin
                if (held_valid) check_val("addr_hold", bus.address_to_l2_ins, held_addr);
                if (addr_wait < addr_stall_cfg) begin
                    addr_wait++;
                    bus.address_to_l2_ready_ins = 1'b0;
                    held_valid = 1'b1;
                    held_addr  = bus.address_to_l2_ins;
                end else begin
                    bus.address_to_l2_ready_ins = 1'b1;
                    addr_wait  = 0;
                    held_valid = 1'b0;
                    n_addr++;
                    mon_addr = bus.address_to_l2_ins;
                    $display("[TB] l2 addr cyc=%0d addr=0x%0h", cyc, mon_addr);
                    resp_q.push_back(mon_addr);
                    if (exp_addr_q.size() == 0) check_val("unexpected_addr", 1, 0);
                    else check_val("l2_addr", mon_addr, exp_addr_q.pop_front());
                end
            end else begin
                if (held_valid) check_val("addr_valid_hold", 0, 1);
                held_valid = 1'b0;
                bus.address_to_l2_ready_ins = 1'b0;
            end
        end
    end

    task automatic push_line(input logic [31:0] a, input int nwrites);
        logic [27:0] line;
        logic [1:0]  off;
        logic [1:0]  o;
        logic [29:0] wa;
        fill_t       f;
        line = a[31:4];
        off  = a[3:2];
        for (int k = 0; k < 4; k++) begin
            o  = off + 2'(k);
            wa = {line, o};
            exp_addr_q.push_back(wa);
            if (k < nwrites) begin
                f.off  = o;
                f.data = l2_word(wa);
                exp_fill_q.push_back(f);
            end
        end
    endtask

    task automatic clear_stats();
        n_addr = 0; n_data = 0; n_write = 0; n_done = 0;
        done_cyc = -1; ready_cyc = -1; accept_cyc = -1;
        fill_cyc_q.delete();
    endtask

    task automatic issue_miss(input logic [31:0] a);
        bit ok;
        ok = 1'b0;
        @(posedge clk); #1;
        bus.miss_valid   = 1'b1;
        bus.miss_address = a;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk); #1;
            if (bus.miss_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check_val("miss_accept", ok, 1);
        @(posedge clk); #1;
        bus.miss_valid = 1'b0;
    endtask

    task automatic wait_line(input int nbeats);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk); #1;
            if (n_data == nbeats && bus.miss_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check_val("line_complete", ok, 1);
        check_val("exp_addr_left", exp_addr_q.size(), 0);
        check_val("exp_fill_left", exp_fill_q.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_miss_ready"}, bus.miss_ready, 1);
        check_val({tag, "_addr_valid"}, bus.address_to_l2_valid_ins, 0);
        check_val({tag, "_addr"}, bus.address_to_l2_ins, 0);
        check_val({tag, "_data_ready"}, bus.data_from_l2_ready_ins, 0);
        check_val({tag, "_fill_we"}, bus.fill_write_enable, 0);
        check_val({tag, "_fill_off"}, bus.fill_word_offset, 0);
        check_val({tag, "_fill_data"}, bus.fill_data, 0);
        check_val({tag, "_fill_done"}, bus.fill_done, 0);
    endtask

    task automatic run_line(input string tag, input logic [31:0] a, input int stall, input int delay);
        clear_stats();
        addr_stall_cfg = stall;
        data_delay_cfg = delay;
        push_line(a, 4);
        issue_miss(a);
        wait_line(4);
        check_val({tag, "_addr_beats"}, n_addr, 4);
        check_val({tag, "_writes"}, n_write, 4);
        check_val({tag, "_done"}, n_done, 1);
    endtask

    initial begin
        bit ok;
        rst = 1'b1;
        bus.miss_valid = 1'b0;
        bus.miss_address = '0;
        bus.flush = 1'b0;
        bus.address_to_l2_ready_ins = 1'b0;
        bus.data_from_l2_valid_ins = 1'b0;
        bus.data_from_l2_ins = '0;
        clear_stats();

        repeat (3) @(negedge clk);
        #1 check_reset_outputs("por");
        rst = 1'b0;
        @(negedge clk); #1;
        check_val("por_release_ready", bus.miss_ready, 1);

        // Reset in the middle of a fill (in RESP, after a word was written)
        clear_stats();
        data_delay_cfg = 3;
        push_line(32'h0000_0100, 4);
        issue_miss(32'h0000_0100);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk); #1;
            if (n_write >= 1 && bus.data_from_l2_ready_ins) begin
                ok = 1'b1;
                break;
            end
        end
        check_val("midfill_reach_resp", ok, 1);
        rst = 1'b1;
        #1 check_reset_outputs("midrst");
        exp_addr_q.delete();
        exp_fill_q.delete();
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk); #1;
        check_val("midrst_release_ready", bus.miss_ready, 1);

        // Aligned miss, zero-wait L2, latency checks
        run_line("aligned", 32'h0000_0100, 0, 0);
        for (int k = 0; k < 4; k++)
            if (k < fill_cyc_q.size()) check_val("aligned_write_cycle", fill_cyc_q[k], accept_cyc + 2 + 2 * k);
        check_val("aligned_done_cycle", done_cyc, accept_cyc + 8);
        check_val("aligned_ready_cycle", ready_cyc, accept_cyc + 9);

        // Critical word first with wrap (byte bits [1:0] ignored)
        run_line("wrap", 32'h0000_010A, 0, 0);

        // Backpressure on both channels
        run_line("bp", 32'h0000_0200, 3, 2);

        // Flush after the second write
        clear_stats();
        addr_stall_cfg = 0;
        data_delay_cfg = 0;
        push_line(32'h0000_0300, 2);
        issue_miss(32'h0000_0300);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk); #1;
            if (n_write == 2) begin
                ok = 1'b1;
                break;
            end
        end
        check_val("flush_reach_second_write", ok, 1);
        @(posedge clk); #1 bus.flush = 1'b1;
        @(posedge clk); #1 bus.flush = 1'b0;
        wait_line(4);
        repeat (3) @(negedge clk);
        check_val("flush_addr_beats", n_addr, 4);
        check_val("flush_data_beats", n_data, 4);
        check_val("flush_writes", n_write, 2);
        check_val("flush_done", n_done, 0);
        check_val("flush_ready_after", bus.miss_ready, 1);

        // Stray data while idle
        clear_stats();
        @(posedge clk); #1 stray = 1'b1;
        repeat (3) @(posedge clk);
        #1 stray = 1'b0;
        repeat (3) @(negedge clk);
        check_val("stray_idle_writes", n_write, 0);

        // Stray data while REQ is stalled, then a normal line
        clear_stats();
        addr_stall_cfg = 6;
        push_line(32'h0000_0404, 4);
        issue_miss(32'h0000_0404);
        stray = 1'b1;
        repeat (3) @(posedge clk);
        #1 stray = 1'b0;
        wait_line(4);
        check_val("stray_req_writes", n_write, 4);
        check_val("stray_req_done", n_done, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got time %0t required completion", $time);
        tests_failed++;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $fatal(1, "timeout");
    end
endmodule
